// File: rtl/muldiv_if.sv
// muldiv_if: request/response channels between the execute stage and the
// iterative multiply/divide unit.
//   request : in_valid / in_ready carrying op (RV32M funct3) and in[1:0]
//             (in[0] = rs1 = a, in[1] = rs2 = b)
//   response: out_valid / out_ready carrying the 32-bit result word
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               op;
    logic [1:0][XLEN-1:0]     in;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out;

    // Execute-stage side: issues requests, consumes results.
    modport master (
        output in_valid, op, in, out_ready,
        input  in_ready, out_valid, out
    );

    // Unit side: accepts requests, produces results.
    modport slave (
        input  in_valid, op, in, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative RV32M multiply/divide unit (IDLE -> BUSY -> DONE).
// One operation in flight; 32 iterations per operation, shift-add multiply
// and restoring divide on operand magnitudes, signs fixed up at the end.
// Divide-by-zero and signed overflow are resolved at accept (no BUSY).
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiplies using
// the * operator on sign/zero-extended operands; divide stays iterative.
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    muldiv_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] b_q, b_d;        // divisor / multiplicand magnitude
    logic [XLEN-1:0] hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;      // multiplier, then product low / quotient
    logic            qneg_q, qneg_d;  // negate product or quotient
    logic            rneg_q, rneg_d;  // negate remainder (sign of a)
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] out_q, out_d;

    // ---------------- accept-time operand decode ----------------
    logic [XLEN-1:0] a_in, b_in, a_mag, b_mag, special_res;
    logic            a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf;

    assign a_in     = bus.in[0];
    assign b_in     = bus.in[1];
    assign is_div   = bus.op[2];
    // MULH, MULHSU, DIV, REM treat a as signed; MULH, DIV, REM treat b as signed.
    assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign sa       = a_signed & a_in[XLEN-1];
    assign sb       = b_signed & b_in[XLEN-1];
    assign a_mag    = sa ? -a_in : a_in;
    assign b_mag    = sb ? -b_in : b_in;
    assign div_zero = is_div && (b_in == '0);
    assign div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) && (a_in == INT_MIN) && (b_in == '1);
    // op[1] distinguishes REM/REMU from DIV/DIVU.
    assign special_res = div_zero ? (bus.op[1] ? a_in : '1)
                                  : (bus.op[1] ? '0   : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     fast_a, fast_b;
    logic [2*XLEN-1:0] fast_p;
    logic [XLEN-1:0]   fast_res;

    assign fast_a   = {sa, a_in};
    assign fast_b   = {sb, b_in};
    // Extending further to 2*XLEN keeps the product exact modulo 2^(2*XLEN).
    assign fast_p   = {{(XLEN-1){fast_a[XLEN]}}, fast_a} * {{(XLEN-1){fast_b[XLEN]}}, fast_b};
    assign fast_res = (bus.op == 3'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

    // ---------------- one iteration of the datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_sub, div_hi, div_lo;
    logic              div_ok;
    logic [XLEN-1:0]   iter_hi, iter_lo;
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   quot_n, rem_n, final_res;

    // Shift-add: conditionally add the multiplicand, then shift {sum, lo} right.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi    = mul_sum[XLEN:1];
    assign mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
    // Restoring divide: shift the next dividend bit in, subtract if it fits.
    // The difference is below b when it fits, so XLEN bits hold it exactly.
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ok    = (div_shift >= {1'b0, b_q});
    assign div_sub   = div_shift[XLEN-1:0] - b_q;
    assign div_hi    = div_ok ? div_sub : div_shift[XLEN-1:0];
    assign div_lo    = {lo_q[XLEN-2:0], div_ok};
    assign iter_hi   = op_q[2] ? div_hi : mul_hi;
    assign iter_lo   = op_q[2] ? div_lo : mul_lo;

    assign prod_n    = qneg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
    assign quot_n    = qneg_q ? -div_lo : div_lo;
    assign rem_n     = rneg_q ? -div_hi : div_hi;

    // Select and sign-correct the result of the final iteration.
    always_comb begin
        final_res = '0;
        case (op_q)
            3'd0:                final_res = prod_n[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_n[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quot_n;
            default:             final_res = rem_n;
        endcase
    end

    // Next-state logic: flush wins, then accept / iterate / hand off.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        count_d = count_q;
        out_d   = out_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_d = bus.op;
                        if (div_zero || div_ovf) begin
                            out_d   = special_res;
                            state_d = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            out_d   = fast_res;
                            state_d = ST_DONE;
`endif
                        end else begin
                            b_d     = b_mag;
                            hi_d    = '0;
                            lo_d    = a_mag;
                            qneg_d  = sa ^ sb;
                            rneg_d  = sa;
                            count_d = CNT_INIT;
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    hi_d = iter_hi;
                    lo_d = iter_lo;
                    if (count_q == '0) begin
                        out_d   = final_res;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out       = out_q;

endmodule
